// File: rtl/lfsr_core.sv
// ---------------------------------------------------------------------------------------------
// lfsr_core: registered LFSR step engine.
//
// Advances an externally held LFSR state by DATA_WIDTH single-bit steps for every accepted beat.
// Both Fibonacci and Galois forms are supported. The block is the shared core behind PRNG,
// scrambler/descrambler and CRC wrappers. The wrapper owns the state register and feeds
// state_out back into state_in.
//
// Parameters
//   LFSR_WIDTH        state width in bits (2..64)
//   LFSR_POLY         feedback polynomial; x^LFSR_WIDTH is implied, bit j (j>=1) selects a tap,
//                     and bit 0 is ignored
//   LFSR_CONFIG       "FIBONACCI" or "GALOIS"; any other value stops elaboration
//   LFSR_FEED_FORWARD 0: each output bit is the feedback bit; 1: each output bit is the raw
//                     input bit
//   REVERSE           1: all buses are LSB-first (bit-reversed around the core computation)
//   DATA_WIDTH        bits processed per beat (1..64)
//
// Ports
//   clk        clock; every register updates on the rising edge
//   rst        synchronous, active-high reset; clears every output and wins over in_valid
//   in_valid   beat qualifier; a step happens only while it is high
//   data_in    input bits; the MSB is processed first
//   state_in   current LFSR state
//   out_valid  high for one cycle after an accepted beat
//   data_out   generated bits (registered)
//   state_out  state after DATA_WIDTH steps (registered)
//   lockup     (only when LFSR_LOCKUP_DETECT_EN is defined) set when an accepted beat leaves an
//              all-zero state in generator mode
//
// Optional feature macro: LFSR_LOCKUP_DETECT_EN
//   defined   -> adds the registered 'lockup' output
//   undefined -> no lockup port and no extra logic
// ---------------------------------------------------------------------------------------------
module lfsr_core #(
  parameter int unsigned           LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter string                 LFSR_CONFIG       = "FIBONACCI",
  parameter bit                    LFSR_FEED_FORWARD = 1'b0,
  parameter bit                    REVERSE           = 1'b0,
  parameter int unsigned           DATA_WIDTH        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
`ifdef LFSR_LOCKUP_DETECT_EN
  ,
  output logic                  lockup
`endif
);

  // -------------------------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------------------------
  localparam bit IsGalois    = (LFSR_CONFIG == "GALOIS");
  localparam bit IsFibonacci = (LFSR_CONFIG == "FIBONACCI");

  if (!IsGalois && !IsFibonacci) begin : g_bad_config
    $error("lfsr_core: LFSR_CONFIG must be \"FIBONACCI\" or \"GALOIS\"");
  end

  if (LFSR_WIDTH < 2 || LFSR_WIDTH > 64) begin : g_bad_lfsr_width
    $error("lfsr_core: LFSR_WIDTH must be in 2..64");
  end

  if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_data_width
    $error("lfsr_core: DATA_WIDTH must be in 1..64");
  end

  // -------------------------------------------------------------------------------------------
  // Input re-ordering
  // The core loop is always written MSB-first. For the LSB-first convention the buses are
  // mirrored on the way in, and mirrored back before they are registered.
  // -------------------------------------------------------------------------------------------
  logic [LFSR_WIDTH-1:0] state_fwd;
  logic [DATA_WIDTH-1:0] data_fwd;

  always_comb begin
    state_fwd = state_in;
    data_fwd  = data_in;
    if (REVERSE) begin
      state_fwd = {<<{state_in}};
      data_fwd  = {<<{data_in}};
    end
  end

  // -------------------------------------------------------------------------------------------
  // Step network
  // The loop is unrolled DATA_WIDTH times into a pure XOR cone; no carries are involved.
  // s_work is the running state and fb is the bit shifted in on each step.
  // -------------------------------------------------------------------------------------------
  logic [LFSR_WIDTH-1:0] state_step;
  logic [DATA_WIDTH-1:0] data_step;

  always_comb begin
    logic [LFSR_WIDTH-1:0] s_work;
    logic                  fb;
    logic                  d;

    s_work    = state_fwd;
    data_step = '0;
    fb        = 1'b0;
    d         = 1'b0;

    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      d = data_fwd[i];

      if (IsGalois) begin
        // Galois: the feedback is just the outgoing MSB plus data.
        // It is injected into every tapped stage after the shift.
        fb     = s_work[LFSR_WIDTH-1] ^ d;
        s_work = {s_work[LFSR_WIDTH-2:0], fb};
        for (int j = 1; j < int'(LFSR_WIDTH); j++) begin
          if (LFSR_POLY[j]) begin
            s_work[j] = s_work[j] ^ fb;
          end
        end
      end else begin
        // Fibonacci: tap j samples stage j-1 (the bit that moves into position j).
        // These taps are XORed into a single feedback bit before the shift.
        fb = s_work[LFSR_WIDTH-1] ^ d;
        for (int j = 1; j < int'(LFSR_WIDTH); j++) begin
          if (LFSR_POLY[j]) begin
            fb = fb ^ s_work[j-1];
          end
        end
        s_work = {s_work[LFSR_WIDTH-2:0], fb};
      end

      // Feed-forward (self-synchronising) mode passes the input bit through unchanged.
      data_step[i] = LFSR_FEED_FORWARD ? d : fb;
    end

    state_step = s_work;
  end

  // -------------------------------------------------------------------------------------------
  // Output re-ordering
  // -------------------------------------------------------------------------------------------
  logic [LFSR_WIDTH-1:0] state_d;
  logic [DATA_WIDTH-1:0] data_d;

  always_comb begin
    state_d = state_step;
    data_d  = data_step;
    if (REVERSE) begin
      state_d = {<<{state_step}};
      data_d  = {<<{data_step}};
    end
  end

  // -------------------------------------------------------------------------------------------
  // Output registers
  // Data and state hold across idle cycles, so a wrapper may sample them late.
  // out_valid is a one-cycle strobe per accepted beat.
  // -------------------------------------------------------------------------------------------
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [LFSR_WIDTH-1:0] state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      state_q <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q  <= data_d;
        state_q <= state_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign data_out  = data_q;
  assign state_out = state_q;

`ifdef LFSR_LOCKUP_DETECT_EN
  // -------------------------------------------------------------------------------------------
  // Lock-up flag
  // An all-zero state is only a problem in generator mode: with zero input data it never
  // leaves zero. In feed-forward mode the state is driven by the input stream, so the flag
  // stays low there. The all-zero test is the same for either bit order.
  // -------------------------------------------------------------------------------------------
  logic lockup_d;
  logic lockup_q;

  always_comb begin
    lockup_d = (state_d == '0) && !LFSR_FEED_FORWARD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lockup_q <= 1'b0;
    end else if (in_valid) begin
      lockup_q <= lockup_d;
    end
  end

  assign lockup = lockup_q;
`endif

endmodule

// File: tb/tb_lfsr_core.sv
// ---------------------------------------------------------------------------------------------
// tb_lfsr_core: self-checking bench for lfsr_core.
// Several instances cover Fibonacci/Galois, multi-bit beats, scrambler pairs, bit reversal and
// DATA_WIDTH > LFSR_WIDTH. Expected values come from an arithmetic reference model
// (shift/mask/parity on 64-bit integers) together with fixed known answers.
// ---------------------------------------------------------------------------------------------
module tb_lfsr_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic vld_a, vld_s, vld_b;

  int n_checks = 0;
  int n_errors = 0;

  // --- group a: W=4 POLY=3 ---
  logic [0:0] fib1_din, fib1_dout;
  logic [3:0] fib1_sin, fib1_sout;
  logic       fib1_ov;
  logic [3:0] fib4_din, fib4_dout, fib4_sin, fib4_sout;
  logic       fib4_ov;
  logic [0:0] gal1_din, gal1_dout;
  logic [3:0] gal1_sin, gal1_sout;
  logic       gal1_ov;
  // --- group s: scrambler pair W=7 POLY=41 DW=8 ---
  logic [7:0] scr_din, scr_dout, dscr_din, dscr_dout;
  logic [6:0] scr_sin, scr_sout, dscr_sin, dscr_sout;
  logic       scr_ov, dscr_ov;
  // --- group b: reversed / wide-data instances ---
  logic [7:0]  rev_din, rev_dout;
  logic [30:0] rev_sin, rev_sout;
  logic        rev_ov;
  logic [11:0] galx_din, galx_dout;
  logic [4:0]  galx_sin, galx_sout;
  logic        galx_ov;
`ifdef LFSR_LOCKUP_DETECT_EN
  logic fib1_lk, fib4_lk, gal1_lk, scr_lk, dscr_lk, rev_lk, galx_lk;
`endif

  lfsr_core #(.LFSR_WIDTH(4), .LFSR_POLY(4'h3), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(1)) u_fib1 (
    .clk(clk), .rst(rst), .in_valid(vld_a), .data_in(fib1_din), .state_in(fib1_sin),
    .out_valid(fib1_ov), .data_out(fib1_dout), .state_out(fib1_sout)
`ifdef LFSR_LOCKUP_DETECT_EN
    , .lockup(fib1_lk)
`endif
  );

  lfsr_core #(.LFSR_WIDTH(4), .LFSR_POLY(4'h3), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(4)) u_fib4 (
    .clk(clk), .rst(rst), .in_valid(vld_a), .data_in(fib4_din), .state_in(fib4_sin),
    .out_valid(fib4_ov), .data_out(fib4_dout), .state_out(fib4_sout)
`ifdef LFSR_LOCKUP_DETECT_EN
    , .lockup(fib4_lk)
`endif
  );

  lfsr_core #(.LFSR_WIDTH(4), .LFSR_POLY(4'h3), .LFSR_CONFIG("GALOIS"),
              .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(1)) u_gal1 (
    .clk(clk), .rst(rst), .in_valid(vld_a), .data_in(gal1_din), .state_in(gal1_sin),
    .out_valid(gal1_ov), .data_out(gal1_dout), .state_out(gal1_sout)
`ifdef LFSR_LOCKUP_DETECT_EN
    , .lockup(gal1_lk)
`endif
  );

  lfsr_core #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(0), .REVERSE(0), .DATA_WIDTH(8)) u_scr (
    .clk(clk), .rst(rst), .in_valid(vld_s), .data_in(scr_din), .state_in(scr_sin),
    .out_valid(scr_ov), .data_out(scr_dout), .state_out(scr_sout)
`ifdef LFSR_LOCKUP_DETECT_EN
    , .lockup(scr_lk)
`endif
  );

  lfsr_core #(.LFSR_WIDTH(7), .LFSR_POLY(7'h41), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(1), .REVERSE(0), .DATA_WIDTH(8)) u_dscr (
    .clk(clk), .rst(rst), .in_valid(vld_s), .data_in(dscr_din), .state_in(dscr_sin),
    .out_valid(dscr_ov), .data_out(dscr_dout), .state_out(dscr_sout)
`ifdef LFSR_LOCKUP_DETECT_EN
    , .lockup(dscr_lk)
`endif
  );

  lfsr_core #(.LFSR_WIDTH(31), .LFSR_POLY(31'h10000001), .LFSR_CONFIG("FIBONACCI"),
              .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(8)) u_rev (
    .clk(clk), .rst(rst), .in_valid(vld_b), .data_in(rev_din), .state_in(rev_sin),
    .out_valid(rev_ov), .data_out(rev_dout), .state_out(rev_sout)
`ifdef LFSR_LOCKUP_DETECT_EN
    , .lockup(rev_lk)
`endif
  );

  lfsr_core #(.LFSR_WIDTH(5), .LFSR_POLY(5'h12), .LFSR_CONFIG("GALOIS"),
              .LFSR_FEED_FORWARD(0), .REVERSE(1), .DATA_WIDTH(12)) u_galx (
    .clk(clk), .rst(rst), .in_valid(vld_b), .data_in(galx_din), .state_in(galx_sin),
    .out_valid(galx_ov), .data_out(galx_dout), .state_out(galx_sout)
`ifdef LFSR_LOCKUP_DETECT_EN
    , .lockup(galx_lk)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned bitrev(input longint unsigned x, input int n);
    longint unsigned r;
    r = 0;
    for (int k = 0; k < n; k++) begin
      if (x[k]) r = r | (64'd1 << (n - 1 - k));
    end
    return r;
  endfunction

  // Reference: DATA_WIDTH steps on an integer state, MSB of data first.
  function automatic void ref_beat(input int w, input longint unsigned poly, input bit galois,
                                   input bit ff, input bit rev, input int dw,
                                   input longint unsigned st_i, input longint unsigned din_i,
                                   output longint unsigned st_o, output longint unsigned dout_o);
    longint unsigned mask, taps, s, din, dout;
    bit d, fb;
    mask = (64'd1 << w) - 1;
    taps = poly & mask & ~64'd1;
    s    = rev ? bitrev(st_i, w) : (st_i & mask);
    din  = rev ? bitrev(din_i, dw) : din_i;
    dout = 0;
    for (int i = dw - 1; i >= 0; i--) begin
      d = din[i];
      if (galois) begin
        fb = s[w-1] ^ d;
        s  = ((s << 1) | 64'(fb)) & mask;
        if (fb) s = s ^ taps;
      end else begin
        fb = s[w-1] ^ d ^ (^((s << 1) & taps));
        s  = ((s << 1) | 64'(fb)) & mask;
      end
      dout = dout | (64'(ff ? d : fb) << i);
    end
    st_o   = rev ? bitrev(s, w) : s;
    dout_o = rev ? bitrev(dout, dw) : dout;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned es, ed, es2, ed2, ms, hold_s, hold_d, h4_s, h4_d;
    longint unsigned xr_s, xr_d, xg_s, xg_d;
    logic [3:0] chain [4];
    int ret_beat;
    logic [7:0] byte_v;
    bit v;

    chain = '{4'b0011, 4'b0111, 4'b1111, 4'b1110};
    rst = 1'b1; vld_a = 0; vld_s = 0; vld_b = 0;
    fib1_din = 0; fib1_sin = 0; fib4_din = 0; fib4_sin = 0; gal1_din = 0; gal1_sin = 0;
    scr_din = 0; scr_sin = 0; dscr_din = 0; dscr_sin = 0;
    rev_din = 0; rev_sin = 0; galx_din = 0; galx_sin = 0;
    tick(); tick();

    // Reset state
    check_eq("rst_fib1_ov", fib1_ov, 0);
    check_eq("rst_fib1_dout", fib1_dout, 0);
    check_eq("rst_fib1_sout", fib1_sout, 0);
    check_eq("rst_scr_sout", scr_sout, 0);
    check_eq("rst_rev_sout", rev_sout, 0);
    check_eq("rst_galx_dout", galx_dout, 0);

    // First beat: known answers for Fibonacci 1-bit, 4-bit and Galois
    rst = 1'b0;
    vld_a = 1; fib1_sin = 4'b0001; fib4_sin = 4'b0001; gal1_sin = 4'b1000;
    tick();
    check_eq("fib1_ov", fib1_ov, 1);
    check_eq("fib1_sout", fib1_sout, 4'b0011);
    check_eq("fib1_dout", fib1_dout, 1);
    check_eq("fib4_sout", fib4_sout, 4'b1110);
    check_eq("fib4_dout", fib4_dout, 4'b1110);
    check_eq("gal1_sout", gal1_sout, 4'b0011);
    check_eq("gal1_dout", gal1_dout, 1);

    // Chain the 1-bit Fibonacci instance around its full period; randomise the others
    ms = 64'b0011;
    ret_beat = 0;
    for (int b = 2; b <= 16; b++) begin
      fib1_sin = 4'(ms); fib1_din = 0;
      fib4_sin = 4'($urandom); fib4_din = 4'($urandom);
      gal1_sin = 4'($urandom); gal1_din = 1'($urandom);
      ref_beat(4, 64'h3, 0, 0, 0, 1, ms, 0, es, ed);
      ref_beat(4, 64'h3, 0, 0, 0, 4, fib4_sin, fib4_din, h4_s, h4_d);
      ref_beat(4, 64'h3, 1, 0, 0, 1, gal1_sin, gal1_din, es2, ed2);
      tick();
      check_eq("fib1_chain_s", fib1_sout, es);
      check_eq("fib1_chain_d", fib1_dout, ed);
      if (b <= 4) check_eq("fib1_chain_known", fib1_sout, chain[b-1]);
      check_eq("fib4_rand_s", fib4_sout, h4_s);
      check_eq("fib4_rand_d", fib4_dout, h4_d);
      check_eq("gal1_rand_s", gal1_sout, es2);
      check_eq("gal1_rand_d", gal1_dout, ed2);
      if (fib1_sout == 4'b0001 && ret_beat == 0) ret_beat = b;
      ms = es;
    end
    check_eq("fib1_period", 64'(ret_beat), 15);

    // Hold: outputs keep the last accepted values while in_valid is low
    hold_s = es; hold_d = ed;
    for (int c = 0; c < 3; c++) begin
      vld_a = 0;
      fib1_sin = 4'($urandom); fib1_din = 1'($urandom); fib4_sin = 4'($urandom);
      tick();
      check_eq("hold_fib1_ov", fib1_ov, 0);
      check_eq("hold_fib1_s", fib1_sout, hold_s);
      check_eq("hold_fib1_d", fib1_dout, hold_d);
      check_eq("hold_fib4_s", fib4_sout, h4_s);
      check_eq("hold_fib4_d", fib4_dout, h4_d);
    end

    // Reset together with in_valid: reset wins
    rst = 1; vld_a = 1; fib1_sin = 4'b0101; fib4_sin = 4'b1001; fib4_din = 4'hf;
    tick();
    check_eq("rstv_fib1_ov", fib1_ov, 0);
    check_eq("rstv_fib1_s", fib1_sout, 0);
    check_eq("rstv_fib1_d", fib1_dout, 0);
    check_eq("rstv_fib4_s", fib4_sout, 0);
    check_eq("rstv_fib4_d", fib4_dout, 0);

    // First beat after reset behaves normally
    rst = 0; vld_a = 1; fib1_sin = 4'b0110; fib1_din = 1;
    ref_beat(4, 64'h3, 0, 0, 0, 1, 64'b0110, 1, es, ed);
    fib4_sin = 0; fib4_din = 0; // all-zero fixed point
    tick();
    check_eq("post_rst_ov", fib1_ov, 1);
    check_eq("post_rst_s", fib1_sout, es);
    check_eq("post_rst_d", fib1_dout, ed);
    check_eq("zero_fp_s", fib4_sout, 0);
    check_eq("zero_fp_d", fib4_dout, 0);
`ifdef LFSR_LOCKUP_DETECT_EN
    check_eq("lockup_set", fib4_lk, 1);
`endif
    fib4_sin = 4'b0001; fib4_din = 0;
    tick();
    check_eq("zero_exit_s", fib4_sout, 4'b1110);
`ifdef LFSR_LOCKUP_DETECT_EN
    check_eq("lockup_clr", fib4_lk, 0);
`endif
    vld_a = 0;

    // Scrambler pair: same seed and same bytes into both
    ms = 64'($urandom_range(1, 127));
    vld_s = 1;
    for (int b = 0; b < 256; b++) begin
      byte_v = 8'($urandom_range(0, 255));
      scr_din = byte_v; dscr_din = byte_v;
      scr_sin = 7'(ms); dscr_sin = 7'(ms);
      ref_beat(7, 64'h41, 0, 0, 0, 8, ms, byte_v, es, ed);
      ref_beat(7, 64'h41, 0, 1, 0, 8, ms, byte_v, es2, ed2);
      tick();
      check_eq("scr_d", scr_dout, ed);
      check_eq("scr_s", scr_sout, es);
      check_eq("dscr_d_orig", dscr_dout, byte_v);
      check_eq("dscr_s", dscr_sout, es2);
      ms = es;
    end
    vld_s = 0;

    // Random beats with gaps on the bit-reversed and wide-data instances
    xr_s = 0; xr_d = 0; xg_s = 0; xg_d = 0;
    for (int b = 0; b < 200; b++) begin
      v = ($urandom_range(0, 3) != 0);
      vld_b = v;
      rev_sin = 31'($urandom); rev_din = 8'($urandom);
      galx_sin = 5'($urandom); galx_din = 12'($urandom);
      if (v) begin
        ref_beat(31, 64'h10000001, 0, 0, 1, 8, rev_sin, rev_din, xr_s, xr_d);
        ref_beat(5, 64'h12, 1, 0, 1, 12, galx_sin, galx_din, xg_s, xg_d);
      end
      tick();
      check_eq("rev_ov", rev_ov, v);
      check_eq("rev_s", rev_sout, xr_s);
      check_eq("rev_d", rev_dout, xr_d);
      check_eq("galx_ov", galx_ov, v);
      check_eq("galx_s", galx_sout, xg_s);
      check_eq("galx_d", galx_dout, xg_d);
    end
    vld_b = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
